// File: rtl/compositor_pkg.sv
// Shared definitions for the layer compositor.
// Contents: colour field widths, bright range, fade FSM state encoding and
// the per-channel brightness scaler used by the output stage.
package compositor_pkg;

    localparam int CH_W     = 4;   // bits per colour channel
    localparam int RGB_W    = 12;  // {r,g,b}
    localparam int CNT_W    = 11;  // timing counter width
    localparam int BRIGHT_W = 5;   // bright holds 0..16

    localparam logic [BRIGHT_W-1:0] BRIGHT_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        BLACK    = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // (c * bright) >> 4 on a 9-bit product; bright=16 returns c unchanged.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                                 input logic [BRIGHT_W-1:0] b);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, b};
        return prod[7:4];
    endfunction

    function automatic logic [RGB_W-1:0] scale_rgb(input logic [RGB_W-1:0] px,
                                                   input logic [BRIGHT_W-1:0] b);
        return {scale_ch(px[11:8], b), scale_ch(px[7:4], b), scale_ch(px[3:0], b)};
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Video bus for the layer compositor.
// Inputs: timing counters/strobes, background and layer pixels, layer
// opacity mask, fade request. Outputs: 2-cycle delayed timing, composited
// pixel, fade status. The slave modport is the compositor's view.
interface layer_compositor_if #(parameter int N_LAYERS = 4);

    logic [10:0]            hcount_in;
    logic [10:0]            vcount_in;
    logic                   hsync_in;
    logic                   vsync_in;
    logic                   hblnk_in;
    logic                   vblnk_in;
    logic [11:0]            bg_rgb_in;
    logic [12*N_LAYERS-1:0] layer_rgb_in;
    logic [N_LAYERS-1:0]    layer_on_in;
    logic                   fade_req;

    logic [10:0]            hcount_out;
    logic [10:0]            vcount_out;
    logic                   hsync_out;
    logic                   vsync_out;
    logic                   hblnk_out;
    logic                   vblnk_out;
    logic [11:0]            rgb_out;
    logic                   fade_busy;
    logic                   black_pulse;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               bg_rgb_in, layer_rgb_in, layer_on_in, fade_req,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
               vblnk_out, rgb_out, fade_busy, black_pulse
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               bg_rgb_in, layer_rgb_in, layer_on_in, fade_req,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
               vblnk_out, rgb_out, fade_busy, black_pulse
    );

endinterface

// File: rtl/layer_compositor_fade_ctrl.sv
// fade_ctrl: frame-edge detector, fade FSM, step/hold counters and the
// bright register.
// Ports: pclk, rst (async active-low), vsync_i, fade_req_i in;
//        bright_o (0..16), fade_busy_o, black_pulse_o out.
module fade_ctrl
    import compositor_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 8
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                vsync_i,
    input  logic                fade_req_i,
    output logic [BRIGHT_W-1:0] bright_o,
    output logic                fade_busy_o,
    output logic                black_pulse_o
);

    localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    fade_state_t         state_q, state_d;
    logic                vs_q;
    logic [3:0]          step_q, step_d;
    logic [7:0]          hold_q, hold_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic                black_q, black_d;
    logic                frame_edge_s;

    assign frame_edge_s = vsync_i & ~vs_q;

    // State, counters, bright and vsync history.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            step_q   <= 4'd0;
            hold_q   <= 8'd0;
            bright_q <= BRIGHT_MAX;
            black_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= vsync_i;
            step_q   <= step_d;
            hold_q   <= hold_d;
            bright_q <= bright_d;
            black_q  <= black_d;
        end
    end

    // Next-state logic; bright only moves on a frame edge. In IDLE a
    // coincident edge is not counted, since counting starts in FADE_OUT.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hold_d   = hold_q;
        bright_d = bright_q;
        black_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fade_req_i) begin
                    state_d = FADE_OUT;
                    step_d  = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            FADE_OUT: begin
                if (frame_edge_s) begin
                    if (step_q == STEP_LAST) begin
                        step_d   = 4'd0;
                        bright_d = bright_q - 5'd1;
                        if (bright_q == 5'd1) begin
                            state_d = BLACK;
                            hold_d  = 8'd0;
                            black_d = 1'b1;
                        end else begin
                            state_d = FADE_OUT;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end else begin
                    state_d = FADE_OUT;
                end
            end
            BLACK: begin
                if (frame_edge_s) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = FADE_IN;
                        step_d  = 4'd0;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end else begin
                    state_d = BLACK;
                end
            end
            FADE_IN: begin
                if (frame_edge_s) begin
                    if (step_q == STEP_LAST) begin
                        step_d   = 4'd0;
                        bright_d = bright_q + 5'd1;
                        if (bright_q == 5'd15) begin
                            state_d = IDLE;
                        end else begin
                            state_d = FADE_IN;
                        end
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end else begin
                    state_d = FADE_IN;
                end
            end
            default: begin
                state_d  = IDLE;
                bright_d = BRIGHT_MAX;
            end
        endcase
    end

    assign bright_o      = bright_q;
    assign fade_busy_o   = (state_q != IDLE);
    assign black_pulse_o = black_q;

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage sprite compositor with frame-synchronous fade.
// Stage 1 picks the lowest-index opaque layer (else background); stage 2
// scales by bright and blanks. Timing strobes are delayed 2 cycles to match.
// Ports: pclk, rst (async active-low), bus (layer_compositor_if.slave).
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int N_LAYERS        = 4,
    parameter int FRAMES_PER_STEP = 2,
    parameter int HOLD_FRAMES     = 8
) (
    input  logic               pclk,
    input  logic               rst,
    layer_compositor_if.slave  bus
);

    logic [BRIGHT_W-1:0] bright_s;
    logic [RGB_W-1:0]    sel_s;
    logic [RGB_W-1:0]    rgb_d;

    logic [RGB_W-1:0]    pix1_q;
    logic [CNT_W-1:0]    h1_q, v1_q, h2_q, v2_q;
    logic                hs1_q, vs1_q, hb1_q, vb1_q;
    logic                hs2_q, vs2_q, hb2_q, vb2_q;
    logic [RGB_W-1:0]    rgb_q;

    fade_ctrl #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .HOLD_FRAMES     (HOLD_FRAMES)
    ) u_fade (
        .pclk          (pclk),
        .rst           (rst),
        .vsync_i       (bus.vsync_in),
        .fade_req_i    (bus.fade_req),
        .bright_o      (bright_s),
        .fade_busy_o   (bus.fade_busy),
        .black_pulse_o (bus.black_pulse)
    );

    // Priority mux: scan high to low so the lowest opaque index wins.
    always_comb begin
        sel_s = bus.bg_rgb_in;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (bus.layer_on_in[k]) begin
                sel_s = bus.layer_rgb_in[12*k +: 12];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Brightness scaling with forced black while the stage-1 blank is high.
    always_comb begin
        if (hb1_q || vb1_q) begin
            rgb_d = 12'h000;
        end else begin
            rgb_d = scale_rgb(pix1_q, bright_s);
        end
    end

    // Two-stage pixel and timing pipeline.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            pix1_q <= 12'h000;
            h1_q   <= 11'd0;
            v1_q   <= 11'd0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            hb1_q  <= 1'b0;
            vb1_q  <= 1'b0;
            h2_q   <= 11'd0;
            v2_q   <= 11'd0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            hb2_q  <= 1'b0;
            vb2_q  <= 1'b0;
            rgb_q  <= 12'h000;
        end else begin
            pix1_q <= sel_s;
            h1_q   <= bus.hcount_in;
            v1_q   <= bus.vcount_in;
            hs1_q  <= bus.hsync_in;
            vs1_q  <= bus.vsync_in;
            hb1_q  <= bus.hblnk_in;
            vb1_q  <= bus.vblnk_in;
            h2_q   <= h1_q;
            v2_q   <= v1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            hb2_q  <= hb1_q;
            vb2_q  <= vb1_q;
            rgb_q  <= rgb_d;
        end
    end

    assign bus.hcount_out = h2_q;
    assign bus.vcount_out = v2_q;
    assign bus.hsync_out  = hs2_q;
    assign bus.vsync_out  = vs2_q;
    assign bus.hblnk_out  = hb2_q;
    assign bus.vblnk_out  = vb2_q;
    assign bus.rgb_out    = rgb_q;

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

    logic pclk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   bp_cnt;

    // Hand-computed (15*b)>>4 for b = 0..16.
    logic [3:0] exp_tab [0:16] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                   4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC,
                                   4'hD, 4'hE, 4'hF};

    layer_compositor_if #(.N_LAYERS(4)) bus();

    layer_compositor #(
        .N_LAYERS        (4),
        .FRAMES_PER_STEP (1),
        .HOLD_FRAMES     (2)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
        if (bus.black_pulse) bp_cnt++;
    endtask

    task automatic frame_edge();
        bus.vsync_in = 1'b1;
        tick(); tick();
        bus.vsync_in = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.hcount_in = 11'd0; bus.vcount_in = 11'd0;
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
        bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b0;
        bus.bg_rgb_in = 12'hFFF; bus.layer_rgb_in = 48'hFFF_FFF_FFF_FFF;
        bus.layer_on_in = 4'b1111; bus.fade_req = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'h000) begin
            n_err++; $display("FAIL reset_rgb: got %h expected 000", bus.rgb_out);
        end
        n_cmp++;
        if ({bus.fade_busy, bus.black_pulse, bus.hsync_out, bus.vsync_out,
             bus.hblnk_out, bus.vblnk_out} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got nonzero expected 0");
        end
        n_cmp++;
        if ({bus.hcount_out, bus.vcount_out} !== 22'd0) begin
            n_err++; $display("FAIL reset_counts: got %h expected 0",
                              {bus.hcount_out, bus.vcount_out});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_background_blank();
        bus.layer_on_in = 4'b0000; bus.bg_rgb_in = 12'h123;
        bus.hcount_in = 11'd100; bus.vcount_in = 11'd200; bus.hsync_in = 1'b1;
        tick();
        n_cmp++;
        if (bus.hcount_out !== 11'd0) begin
            n_err++; $display("FAIL delay_1cyc: got %0d expected 0", bus.hcount_out);
        end
        tick();
        n_cmp++;
        if (bus.rgb_out !== 12'h123) begin
            n_err++; $display("FAIL background: got %h expected 123", bus.rgb_out);
        end
        n_cmp++;
        if ({bus.hcount_out, bus.vcount_out, bus.hsync_out} !== {11'd100, 11'd200, 1'b1}) begin
            n_err++; $display("FAIL timing_delay2: got %0d/%0d/%b expected 100/200/1",
                              bus.hcount_out, bus.vcount_out, bus.hsync_out);
        end
        bus.hblnk_in = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'h000) begin
            n_err++; $display("FAIL hblank: got %h expected 000", bus.rgb_out);
        end
        n_cmp++;
        if (bus.hblnk_out !== 1'b1) begin
            n_err++; $display("FAIL hblnk_out: got %b expected 1", bus.hblnk_out);
        end
        bus.hblnk_in = 1'b0; bus.vblnk_in = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'h000) begin
            n_err++; $display("FAIL vblank: got %h expected 000", bus.rgb_out);
        end
        bus.vblnk_in = 1'b0; bus.hsync_in = 1'b0;
        tick(); tick();
    endtask

    task automatic test_priority();
        bus.layer_rgb_in = {12'hABC, 12'h0F0, 12'hF00, 12'h555};
        bus.bg_rgb_in = 12'h00F;
        bus.layer_on_in = 4'b0110;
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'hF00) begin
            n_err++; $display("FAIL prio_0110: got %h expected F00", bus.rgb_out);
        end
        bus.layer_on_in = 4'b1000;
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'hABC) begin
            n_err++; $display("FAIL prio_1000: got %h expected ABC", bus.rgb_out);
        end
        bus.layer_on_in = 4'b1111;
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'h555) begin
            n_err++; $display("FAIL prio_1111: got %h expected 555", bus.rgb_out);
        end
    endtask

    task automatic test_full_fade(input bit second_req);
        int b;
        bus.layer_on_in = 4'b0000; bus.bg_rgb_in = 12'hFFF;
        tick(); tick();
        bp_cnt = 0;
        bus.fade_req = 1'b1;
        tick();
        bus.fade_req = 1'b0;
        n_cmp++;
        if (bus.fade_busy !== 1'b1) begin
            n_err++; $display("FAIL fade_start_busy: got %b expected 1", bus.fade_busy);
        end
        for (int e = 1; e <= 34; e++) begin
            frame_edge();
            if (second_req && e == 3) begin
                bus.fade_req = 1'b1;
                tick();
                bus.fade_req = 1'b0;
            end
            b = (e <= 16) ? 16 - e : (e <= 18) ? 0 : e - 18;
            n_cmp++;
            if (bus.rgb_out !== {3{exp_tab[b]}}) begin
                n_err++; $display("FAIL fade_rgb edge %0d: got %h expected %h",
                                  e, bus.rgb_out, {3{exp_tab[b]}});
            end
            n_cmp++;
            if (bus.fade_busy !== (e < 34)) begin
                n_err++; $display("FAIL fade_busy edge %0d: got %b expected %b",
                                  e, bus.fade_busy, (e < 34));
            end
            if (e == 8) begin
                n_cmp++;
                if (bus.rgb_out !== 12'h777) begin
                    n_err++; $display("FAIL half_bright: got %h expected 777", bus.rgb_out);
                end
            end
        end
        n_cmp++;
        if (bp_cnt !== 1) begin
            n_err++; $display("FAIL black_pulse_count: got %0d expected 1", bp_cnt);
        end
        n_cmp++;
        if (bus.rgb_out !== 12'hFFF) begin
            n_err++; $display("FAIL fade_restored: got %h expected FFF", bus.rgb_out);
        end
    endtask

    task automatic test_coincident_then_reset();
        bus.layer_on_in = 4'b0000; bus.bg_rgb_in = 12'hFFF;
        bus.fade_req = 1'b1; bus.vsync_in = 1'b1;
        tick();
        bus.fade_req = 1'b0;
        tick();
        bus.vsync_in = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'hFFF) begin
            n_err++; $display("FAIL coincident_bright: got %h expected FFF", bus.rgb_out);
        end
        n_cmp++;
        if (bus.fade_busy !== 1'b1) begin
            n_err++; $display("FAIL coincident_busy: got %b expected 1", bus.fade_busy);
        end
        frame_edge();
        n_cmp++;
        if (bus.rgb_out !== 12'hEEE) begin
            n_err++; $display("FAIL coincident_first_step: got %h expected EEE", bus.rgb_out);
        end
        for (int e = 0; e < 10; e++) frame_edge();
        n_cmp++;
        if (bus.rgb_out !== 12'h444) begin
            n_err++; $display("FAIL bright5: got %h expected 444", bus.rgb_out);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rgb_out, bus.fade_busy} !== 13'd0) begin
            n_err++; $display("FAIL midfade_reset: got %h/%b expected 000/0",
                              bus.rgb_out, bus.fade_busy);
        end
        tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'h000) begin
            n_err++; $display("FAIL reset_hold_rgb: got %h expected 000", bus.rgb_out);
        end
        rst = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (bus.rgb_out !== 12'hFFF) begin
            n_err++; $display("FAIL post_reset_rgb: got %h expected FFF", bus.rgb_out);
        end
        n_cmp++;
        if (bus.fade_busy !== 1'b0) begin
            n_err++; $display("FAIL post_reset_busy: got %b expected 0", bus.fade_busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bp_cnt = 0;
        test_reset();
        test_background_blank();
        test_priority();
        test_full_fade(1'b0);
        test_full_fade(1'b1);
        test_coincident_then_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
